id_ex_pipe_reg: RTL
===================

# id_ex_pipe_reg

Parametrised ID/EX pipeline stage register between decode and execute. It carries the PC, the register-file operands, the immediate, the instruction, the destination register and the decoded control bundles into EX. Transfers use a valid/ready handshake, so the stage can stall and hold its contents, and a synchronous flush inserts a bubble. The stage also keeps a saturating stall-cycle counter for performance debug.

## Interface
Parameters:
- XLEN, 64, data/address width (PC, operands, immediate)
- ILEN, 32, instruction width
- REG_AW, 5, register-address width
- CNT_W, 32, stall counter width

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-low reset
- in_valid  in  1  decode presents a beat
- in_ready  out  1  stage accepts the beat this cycle
- flush  in  1  synchronous kill of all held beats
- pc_in, rs1_data, rs2_data, imm_in  in  XLEN  beat payload
- instr_in  in  ILEN  instruction
- rd_in  in  REG_AW  destination register
- alu_src, mem_to_reg, reg_write, mem_read, mem_write, branch  in  1  control
- alu_op  in  2  ALU operation class
- out_valid  out  1  EX-side beat valid
- out_ready  in  1  EX consumes the beat
- pc_out, rs1_out, rs2_out, imm_out  out  XLEN  registered payload
- instr_out  out  ILEN; rd_out  out  REG_AW
- alu_ctl  out  4  {instr[30], instr[14:12]} of the held instruction
- wb_ctl  out  2  {reg_write, mem_to_reg}
- m_ctl  out  3  {mem_read, mem_write, branch}
- ex_ctl  out  3  {alu_src, alu_op}
- stall_cnt  out  CNT_W  saturating count of cycles with in_valid & !in_ready

## Operation
- Handshake: a beat transfers in when in_valid & in_ready, and out when out_valid & out_ready. Payload is stable while out_valid & !out_ready.
- Without skid: in_ready = !out_valid | out_ready. On accept, all outputs load together and out_valid sets. On consume without accept, out_valid clears.
- Bubble rule: when out_valid=0, wb_ctl, m_ctl, ex_ctl and alu_ctl read 0. The data outputs hold their last value.
- Flush (highest priority): out_valid and every internal valid clear at the next edge. A beat accepted in the flush cycle is discarded. Data registers are not cleared.
- Reset (asynchronous, any time): all valids are 0, all outputs are 0, stall_cnt=0. in_ready reads 1 once reset is released.
- stall_cnt increments every cycle in which in_valid & !in_ready, saturating at all-ones. flush does not clear it; only reset does.

## Timing
- Latency: 1 cycle, from the accept edge to out_valid.
- Throughput: 1 beat/cycle while out_ready=1.
- Simultaneous consume and accept: the new beat replaces the old one; out_valid stays 1.
- Simultaneous flush and out_ready: the consume still counts on the EX side that cycle; the stage is empty next cycle.
- Reset asserted mid-stall: outputs go to 0 asynchronously, before the next edge.

## Configuration
- ID_EX_SKID_EN defined:
  - A one-entry skid buffer is added, and in_ready is a registered signal equal to !skid_valid, so there is no combinational path from out_ready.
  - A beat accepted while the output is stalled goes to the skid buffer. The skid beat moves to the output on the edge where the output is consumed.
  - in_ready drops the cycle after the skid buffer fills, and rises the cycle after it drains. Order is preserved.
  - Flush clears the skid buffer as well.
- ID_EX_SKID_EN undefined: no skid storage; in_ready is combinational as described under Operation.

## Test plan
- Reset then stream: release reset, send pc_in=0x100, 0x104 and 0x108 back-to-back with out_ready=1. Required: out_valid rises 1 cycle after the first accept; pc_out reads 0x100, 0x104, 0x108 on consecutive cycles; stall_cnt=0.
- Stall hold: load instr_in=0x40B50533, then hold out_ready=0 for 3 cycles. Required: all outputs stable, alu_ctl=4'b1000, stall_cnt=3 with in_valid held at 1 (without skid; with skid, 2).
- Flush: flush=1 while out_valid=1, reg_write=1 and in_valid=1. Required: next cycle out_valid=0 and wb_ctl=m_ctl=ex_ctl=0; the accepted beat never appears.
- Skid ordering (ID_EX_SKID_EN): accept beats A and B with out_ready=0, then raise out_ready. Required: in_ready=0 the cycle after B; outputs show A, then B; in_ready returns to 1 the cycle after the skid buffer drains.
- Async reset mid-stall: drop reset between edges while out_valid=1. Required: out_valid=0 and all outputs 0 immediately, stall_cnt=0.
- Counter saturation (CNT_W=4): hold in_valid=1, out_ready=0 for 20 cycles. Required: stall_cnt stays at 4'hF.

Source files
------------

// File: rtl/id_ex_pipe_reg.sv
// ID/EX pipeline stage register with valid/ready handshake, synchronous flush
// and a saturating stall-cycle counter.
// Optional feature: define ID_EX_SKID_EN to add a one-entry skid buffer that
// registers in_ready, which removes the combinational path from out_ready.
module id_ex_pipe_reg #(
    parameter int unsigned XLEN   = 64,
    parameter int unsigned ILEN   = 32,
    parameter int unsigned REG_AW = 5,
    parameter int unsigned CNT_W  = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              flush,
    input  logic [XLEN-1:0]   pc_in,
    input  logic [XLEN-1:0]   rs1_data,
    input  logic [XLEN-1:0]   rs2_data,
    input  logic [XLEN-1:0]   imm_in,
    input  logic [ILEN-1:0]   instr_in,
    input  logic [REG_AW-1:0] rd_in,
    input  logic              alu_src,
    input  logic              mem_to_reg,
    input  logic              reg_write,
    input  logic              mem_read,
    input  logic              mem_write,
    input  logic              branch,
    input  logic [1:0]        alu_op,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [XLEN-1:0]   pc_out,
    output logic [XLEN-1:0]   rs1_out,
    output logic [XLEN-1:0]   rs2_out,
    output logic [XLEN-1:0]   imm_out,
    output logic [ILEN-1:0]   instr_out,
    output logic [REG_AW-1:0] rd_out,
    output logic [3:0]        alu_ctl,
    output logic [1:0]        wb_ctl,
    output logic [2:0]        m_ctl,
    output logic [2:0]        ex_ctl,
    output logic [CNT_W-1:0]  stall_cnt
);

    // Payload is carried as one flat vector: four XLEN words, instruction, rd, 8 control bits.
    localparam int unsigned PW = 4 * XLEN + ILEN + REG_AW + 8;

    logic [PW-1:0]    beat_in;
    logic [PW-1:0]    out_q, out_d;
    logic             out_valid_q, out_valid_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic             accept, consume;

    logic             held_alu_src, held_mem_to_reg, held_reg_write;
    logic             held_mem_read, held_mem_write, held_branch;
    logic [1:0]       held_alu_op;

    assign beat_in = {pc_in, rs1_data, rs2_data, imm_in, instr_in, rd_in,
                      alu_src, alu_op, mem_to_reg, reg_write, mem_read, mem_write, branch};

    assign consume = out_valid_q & out_ready;
    assign accept  = in_valid & in_ready;

`ifdef ID_EX_SKID_EN
    logic [PW-1:0] skid_q, skid_d;
    logic          skid_valid_q, skid_valid_d;

    // in_ready depends only on state, so out_ready never reaches it combinationally.
    assign in_ready = reset & ~skid_valid_q;

    // Output slot refills from the skid entry first so order is preserved.
    always_comb begin
        out_d        = out_q;
        out_valid_d  = out_valid_q;
        skid_d       = skid_q;
        skid_valid_d = skid_valid_q;
        if (!out_valid_q || consume) begin
            if (skid_valid_q) begin
                out_d        = skid_q;
                out_valid_d  = 1'b1;
                skid_valid_d = 1'b0;
            end else begin
                out_valid_d = accept;
                if (accept) begin
                    out_d = beat_in;
                end
            end
        end else if (accept) begin
            skid_d       = beat_in;
            skid_valid_d = 1'b1;
        end
        // Flush kills every held beat but leaves data storage untouched.
        if (flush) begin
            out_d        = out_q;
            out_valid_d  = 1'b0;
            skid_d       = skid_q;
            skid_valid_d = 1'b0;
        end
    end

    // Skid storage.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            skid_q       <= '0;
            skid_valid_q <= 1'b0;
        end else begin
            skid_q       <= skid_d;
            skid_valid_q <= skid_valid_d;
        end
    end
`else
    assign in_ready = reset & (~out_valid_q | out_ready);

    // Load on accept, empty on consume; flush discards any beat accepted this cycle.
    always_comb begin
        out_d       = out_q;
        out_valid_d = out_valid_q;
        if (accept) begin
            out_d       = beat_in;
            out_valid_d = 1'b1;
        end else if (consume) begin
            out_valid_d = 1'b0;
        end
        if (flush) begin
            out_d       = out_q;
            out_valid_d = 1'b0;
        end
    end
`endif

    // Saturating count of cycles in which decode is held off.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (in_valid && !in_ready && (stall_cnt_q != {CNT_W{1'b1}})) begin
            stall_cnt_d = stall_cnt_q + 1'b1;
        end
    end

    // Output stage and counter state.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            out_q       <= '0;
            out_valid_q <= 1'b0;
            stall_cnt_q <= '0;
        end else begin
            out_q       <= out_d;
            out_valid_q <= out_valid_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign {pc_out, rs1_out, rs2_out, imm_out, instr_out, rd_out,
            held_alu_src, held_alu_op, held_mem_to_reg, held_reg_write,
            held_mem_read, held_mem_write, held_branch} = out_q;

    // Control bundles read as zero for a bubble; data outputs keep their last value.
    assign out_valid = out_valid_q;
    assign alu_ctl   = out_valid_q ? {instr_out[30], instr_out[14:12]} : 4'b0;
    assign wb_ctl    = out_valid_q ? {held_reg_write, held_mem_to_reg} : 2'b0;
    assign m_ctl     = out_valid_q ? {held_mem_read, held_mem_write, held_branch} : 3'b0;
    assign ex_ctl    = out_valid_q ? {held_alu_src, held_alu_op} : 3'b0;
    assign stall_cnt = stall_cnt_q;

endmodule
